// File: rtl/riscv_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline: drives the
// stage-register enable/clear pairs and the PC enable, and counts stalls and flushes.
module riscv_pipeline_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_memrd,
    input  logic             i_ex_br_taken,
    input  logic             i_imem_ready,
    input  logic             i_mem_req,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_en_ifid,
    output logic             o_en_idex,
    output logic             o_en_exmem,
    output logic             o_en_memwb,
    output logic             o_clr_ifid,
    output logic             o_clr_idex,
    output logic             o_clr_exmem,
    output logic             o_clr_memwb,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_DMEM_WAIT = 2'd2,
        ST_DISCARD   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [BW-1:0]     r_boot_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_dmem_wait;
    logic              w_load_use;
    logic              w_flush_inc;
    logic              w_stall_inc;

    assign w_dmem_wait = i_mem_req & ~i_dmem_ready;
    assign w_load_use  = i_ex_memrd & (i_ex_rd != 5'd0) &
                         ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                          (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

    // State, boot countdown and saturating performance counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= BW'(BOOT_CYCLES - 1);
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_BOOT && r_boot_cnt != '0) begin
                r_boot_cnt <= r_boot_cnt - BW'(1);
            end
            if (w_stall_inc && r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && r_flush_cnt != {CNT_W{1'b1}}) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and zero-latency stage controls, resolved by hazard priority
    always_comb begin
        w_next_state = r_state;
        w_flush_inc  = 1'b0;
        o_pc_en      = 1'b1;
        o_en_ifid    = 1'b1;
        o_en_idex    = 1'b1;
        o_en_exmem   = 1'b1;
        o_en_memwb   = 1'b1;
        o_clr_ifid   = 1'b0;
        o_clr_idex   = 1'b0;
        o_clr_exmem  = 1'b0;
        o_clr_memwb  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                o_pc_en     = 1'b0;
                o_clr_ifid  = 1'b1;
                o_clr_idex  = 1'b1;
                o_clr_exmem = 1'b1;
                o_clr_memwb = 1'b1;
                if (r_boot_cnt == '0) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_BOOT;
                end
            end
            ST_RUN, ST_DMEM_WAIT: begin
                if (w_dmem_wait) begin
                    // Freeze everything upstream; MEM/WB takes a bubble so WB does not repeat
                    o_pc_en      = 1'b0;
                    o_en_ifid    = 1'b0;
                    o_en_idex    = 1'b0;
                    o_en_exmem   = 1'b0;
                    o_clr_memwb  = 1'b1;
                    w_next_state = ST_DMEM_WAIT;
                end else if (i_ex_br_taken) begin
                    o_clr_ifid   = 1'b1;
                    o_clr_idex   = 1'b1;
                    w_flush_inc  = 1'b1;
                    if (i_imem_ready) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_DISCARD;
                    end
                end else if (w_load_use) begin
                    o_pc_en      = 1'b0;
                    o_en_ifid    = 1'b0;
                    o_clr_idex   = 1'b1;
                    w_next_state = ST_RUN;
                end else if (!i_imem_ready) begin
                    o_pc_en      = 1'b0;
                    o_clr_ifid   = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DISCARD: begin
                if (w_dmem_wait) begin
                    o_pc_en      = 1'b0;
                    o_en_ifid    = 1'b0;
                    o_en_idex    = 1'b0;
                    o_en_exmem   = 1'b0;
                    o_clr_memwb  = 1'b1;
                    w_next_state = ST_DISCARD;
                end else begin
                    // The stale fetch response is dropped when it finally arrives
                    o_pc_en    = 1'b0;
                    o_clr_ifid = 1'b1;
                    if (i_imem_ready) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_DISCARD;
                    end
                end
            end
            default: begin
                o_pc_en      = 1'b0;
                o_clr_ifid   = 1'b1;
                o_clr_idex   = 1'b1;
                o_clr_exmem  = 1'b1;
                o_clr_memwb  = 1'b1;
                w_next_state = ST_BOOT;
            end
        endcase
    end

    assign w_stall_inc = (r_state != ST_BOOT) & ~o_pc_en;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// Self-checking bench for riscv_pipeline_ctrl: directed test-plan steps followed by
// randomized cycles, all compared against a priority-rule reference model.
module tb_riscv_pipeline_ctrl;

    localparam int BOOT = 4;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [4:0]    i_id_rs1, i_id_rs2, i_ex_rd;
    logic          i_id_rs1_used, i_id_rs2_used, i_ex_memrd, i_ex_br_taken;
    logic          i_imem_ready, i_mem_req, i_dmem_ready;
    logic          o_pc_en, o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb;
    logic          o_clr_ifid, o_clr_idex, o_clr_exmem, o_clr_memwb;
    logic [CW-1:0] o_stall_cnt, o_flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: boot cycles still to run, pending stale-fetch drop, counters
    int m_boot_left;
    bit m_discard;
    int m_stall;
    int m_flush;
    bit m_valid = 1'b0;

    riscv_pipeline_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd(i_ex_rd), .i_ex_memrd(i_ex_memrd), .i_ex_br_taken(i_ex_br_taken),
        .i_imem_ready(i_imem_ready), .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
        .o_pc_en(o_pc_en), .o_en_ifid(o_en_ifid), .o_en_idex(o_en_idex),
        .o_en_exmem(o_en_exmem), .o_en_memwb(o_en_memwb),
        .o_clr_ifid(o_clr_ifid), .o_clr_idex(o_clr_idex),
        .o_clr_exmem(o_clr_exmem), .o_clr_memwb(o_clr_memwb),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected controls as {pc_en, en[ifid,idex,exmem,memwb], clr[ifid,idex,exmem,memwb]}
    function automatic logic [8:0] model_ctl();
        logic       lu;
        lu = i_ex_memrd && (i_ex_rd != 5'd0) &&
             ((i_id_rs1_used && i_id_rs1 == i_ex_rd) || (i_id_rs2_used && i_id_rs2 == i_ex_rd));
        if (m_boot_left > 0)                   return 9'b0_1111_1111;
        else if (i_mem_req && !i_dmem_ready)   return 9'b0_0001_0001;
        else if (m_discard)                    return 9'b0_1111_1000;
        else if (i_ex_br_taken)                return 9'b1_1111_1100;
        else if (lu)                           return 9'b0_0111_0100;
        else if (!i_imem_ready)                return 9'b0_1111_1000;
        else                                   return 9'b1_1111_0000;
    endfunction

    task automatic model_advance(input logic pc_en_exp);
        if (i_rst) begin
            m_boot_left = BOOT;
            m_discard   = 1'b0;
            m_stall     = 0;
            m_flush     = 0;
            m_valid     = 1'b1;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else begin
            if (!pc_en_exp && m_stall < SAT) m_stall++;
            if (!(i_mem_req && !i_dmem_ready)) begin
                if (m_discard) begin
                    if (i_imem_ready) m_discard = 1'b0;
                end else if (i_ex_br_taken) begin
                    if (m_flush < SAT) m_flush++;
                    if (!i_imem_ready) m_discard = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        logic [8:0] exp;
        #2;
        exp = model_ctl();
        if (m_valid) begin
            check({tag, " ctl"}, {23'd0, o_pc_en, o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb,
                                  o_clr_ifid, o_clr_idex, o_clr_exmem, o_clr_memwb}, {23'd0, exp});
            check({tag, " stall_cnt"}, {28'd0, o_stall_cnt}, m_stall);
            check({tag, " flush_cnt"}, {28'd0, o_flush_cnt}, m_flush);
        end
        @(posedge i_clk);
        model_advance(exp[8]);
        #1;
    endtask

    task automatic idle();
        i_rst = 1'b0; i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_ex_rd = 5'd0;
        i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0; i_ex_memrd = 1'b0; i_ex_br_taken = 1'b0;
        i_imem_ready = 1'b1; i_mem_req = 1'b0; i_dmem_ready = 1'b1;
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        step("reset0");
        step("reset1");
        i_rst = 1'b0;

        // Boot window then first RUN cycle
        for (int i = 0; i < BOOT; i++) begin
            #2;
            check("boot pc_en", {31'd0, o_pc_en}, 32'd0);
            step("boot");
        end
        #2;
        check("run0 pc_en", {31'd0, o_pc_en}, 32'd1);
        step("run0");

        // Load-use on rs2, then the same with rd=x0 (no hazard)
        i_ex_memrd = 1'b1; i_ex_rd = 5'd5; i_id_rs2 = 5'd5; i_id_rs2_used = 1'b1;
        step("loaduse");
        idle();
        step("after_lu");
        check("lu stall_cnt", {28'd0, o_stall_cnt}, 32'd1);
        i_ex_memrd = 1'b1; i_ex_rd = 5'd0; i_id_rs2 = 5'd0; i_id_rs2_used = 1'b1;
        step("lu_x0");
        idle();
        check("lu_x0 stall_cnt", {28'd0, o_stall_cnt}, 32'd1);

        // Redirect with stale fetch in flight: 3 DISCARD cycles
        i_ex_br_taken = 1'b1; i_imem_ready = 1'b0;
        step("redirect");
        i_ex_br_taken = 1'b0;
        step("discard0");
        step("discard1");
        i_imem_ready = 1'b1;
        step("discard2");
        step("after_discard");
        check("redirect flush_cnt", {28'd0, o_flush_cnt}, 32'd1);

        // dmem wait masks coincident redirect and load-use
        i_mem_req = 1'b1; i_dmem_ready = 1'b0; i_ex_br_taken = 1'b1;
        i_ex_memrd = 1'b1; i_ex_rd = 5'd7; i_id_rs1 = 5'd7; i_id_rs1_used = 1'b1;
        for (int i = 0; i < 3; i++) step("dmem_wait");
        check("dmem flush_cnt", {28'd0, o_flush_cnt}, 32'd1);
        i_dmem_ready = 1'b1;
        step("dmem_release");
        idle();
        check("dmem_release flush_cnt", {28'd0, o_flush_cnt}, 32'd2);

        // Long imem stall saturates the stall counter
        i_imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) step("imem_wait");
        check("stall saturate", {28'd0, o_stall_cnt}, SAT);
        idle();

        // Reset while in DISCARD
        i_ex_br_taken = 1'b1; i_imem_ready = 1'b0;
        step("redirect2");
        i_ex_br_taken = 1'b0; i_rst = 1'b1;
        step("rst_in_discard");
        i_rst = 1'b0;
        #2;
        check("post_rst pc_en", {31'd0, o_pc_en}, 32'd0);
        check("post_rst stall_cnt", {28'd0, o_stall_cnt}, 32'd0);
        check("post_rst flush_cnt", {28'd0, o_flush_cnt}, 32'd0);
        step("post_rst");

        // Randomized cycles
        for (int i = 0; i < 600; i++) begin
            i_rst         = ($urandom_range(0, 79) == 0);
            i_id_rs1      = 5'($urandom_range(0, 3));
            i_id_rs2      = 5'($urandom_range(0, 3));
            i_ex_rd       = 5'($urandom_range(0, 3));
            i_id_rs1_used = 1'($urandom_range(0, 1));
            i_id_rs2_used = 1'($urandom_range(0, 1));
            i_ex_memrd    = ($urandom_range(0, 2) == 0);
            i_ex_br_taken = ($urandom_range(0, 5) == 0);
            i_imem_ready  = ($urandom_range(0, 3) != 0);
            i_mem_req     = ($urandom_range(0, 3) == 0);
            i_dmem_ready  = 1'($urandom_range(0, 1));
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
